// File: rtl/acc61_pkg.sv
// Shared widths and FSM state encoding for the acc61 accumulate sequencer.
// Imported by acc61_if, acc61_zext_add and acc61_sequencer.
package acc61_pkg;

  localparam int ACC_W = 61;
  localparam int PP_W  = 45;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/acc61_if.sv
// Start / partial-product / result handshake bundle of acc61_sequencer.
// master: job source and result consumer; slave: the sequencer.
interface acc61_if
  import acc61_pkg::*;
#(
  parameter int AW = ACC_W,
  parameter int PW = PP_W,
  parameter int CW = CNT_W
);

  logic          start_valid;
  logic          start_ready;
  logic [AW-1:0] start_init;
  logic [CW-1:0] start_count;
  logic          pp_valid;
  logic          pp_ready;
  logic [PW-1:0] pp_data;
  logic          res_valid;
  logic          res_ready;
  logic [AW-1:0] res_data;
  logic          res_ovf;
  logic          busy;

  modport master (
    output start_valid, start_init, start_count,
    output pp_valid, pp_data, res_ready,
    input  start_ready, pp_ready, res_valid,
    input  res_data, res_ovf, busy
  );

  modport slave (
    input  start_valid, start_init, start_count,
    input  pp_valid, pp_data, res_ready,
    output start_ready, pp_ready, res_valid,
    output res_data, res_ovf, busy
  );

endinterface

// File: rtl/acc61_zext_add.sv
// Combinational adder pass: sum = a + zero-extended b, with carry-out.
// Ports: a (AW), b (PW), sum (AW+1, MSB is carry-out).
module acc61_zext_add
  import acc61_pkg::*;
#(
  parameter int AW = ACC_W,
  parameter int PW = PP_W
) (
  input  logic [AW-1:0] a,
  input  logic [PW-1:0] b,
  output logic [AW:0]   sum
);

  logic [AW:0] b_ext;

  assign b_ext = {{(AW + 1 - PW){1'b0}}, b};
  assign sum   = {1'b0, a} + b_ext;

endmodule

// File: rtl/acc61_sequencer.sv
// Multi-cycle 61b += 45b accumulate controller (IDLE/ACCUM/DONE).
// Ports: clk, rst (sync, active-high), bus (acc61_if.slave).
// Optional ACC61_OVF_FLAG_EN: sticky carry-out reported on res_ovf.
module acc61_sequencer
  import acc61_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  acc61_if.slave   bus
);

  state_e             state;
  state_e             state_n;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   remaining;
  logic [ACC_W:0]     sum;
  logic               start_ready_q;
  logic               pp_ready_q;
  logic               res_valid_q;
  logic               busy_q;
  logic               start_hs;
  logic               pp_hs;
  logic               res_hs;

  acc61_zext_add #(
    .AW (ACC_W),
    .PW (PP_W)
  ) u_add (
    .a   (acc),
    .b   (bus.pp_data),
    .sum (sum)
  );

  assign start_hs = bus.start_valid & start_ready_q;
  assign pp_hs    = bus.pp_valid & pp_ready_q;
  assign res_hs   = res_valid_q & bus.res_ready;

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (start_hs)
          state_n = (bus.start_count == '0) ? ST_DONE : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (pp_hs && remaining == CNT_W'(1))
          state_n = ST_DONE;
      end
      ST_DONE: begin
        if (res_hs)
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      acc           <= '0;
      remaining     <= '0;
      start_ready_q <= 1'b1;
      pp_ready_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state         <= state_n;
      start_ready_q <= (state_n == ST_IDLE);
      pp_ready_q    <= (state_n == ST_ACCUM);
      res_valid_q   <= (state_n == ST_DONE);
      busy_q        <= (state_n != ST_IDLE);
      if (start_hs) begin
        acc       <= bus.start_init;
        remaining <= bus.start_count;
      end else if (pp_hs) begin
        acc       <= sum[ACC_W-1:0];
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

`ifdef ACC61_OVF_FLAG_EN
  logic ovf;

  always_ff @(posedge clk) begin
    if (rst)
      ovf <= 1'b0;
    else if (start_hs)
      ovf <= 1'b0;
    else if (pp_hs)
      ovf <= ovf | sum[ACC_W];
  end

  assign bus.res_ovf = ovf;
`else
  logic unused_carry;

  assign unused_carry = sum[ACC_W];
  assign bus.res_ovf  = 1'b0;
`endif

  assign bus.start_ready = start_ready_q;
  assign bus.pp_ready    = pp_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.busy        = busy_q;
  assign bus.res_data    = acc;

endmodule
